// File: rtl/vslc_timer_pkg.sv
`default_nettype none
// ============================================================================
// vslc_timer_pkg : shared types and constants for the VSLC timer bank
// Rev 1.0
// ============================================================================
package vslc_timer_pkg;

  typedef enum logic [1:0] {
    TMR_CYCLE    = 2'd0,
    TMR_ONESHOT  = 2'd1,
    TMR_RETRIG   = 2'd2,
    TMR_DELAY_ON = 2'd3
  } tmr_mode_e;

  localparam logic [1:0] CFG_PA   = 2'd0;
  localparam logic [1:0] CFG_PB   = 2'd1;
  localparam logic [1:0] CFG_CTRL = 2'd2;
  localparam logic [1:0] CFG_RSVD = 2'd3;

  localparam int PA_RST = 1;
  localparam int PB_RST = 2;

endpackage
`default_nettype wire

// File: rtl/vslc_timer_bank_if.sv
`default_nettype none
// ============================================================================
// vslc_timer_bank_if : executor-to-timer-bank strobe, config and status bus
// Rev 1.0
// ============================================================================
interface vslc_timer_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 10,
  parameter int CH_W  = 2
);
  logic [N_CH-1:0]  start;
  logic [N_CH-1:0]  stop;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic             cfg_err;
  logic [N_CH-1:0]  tmr_out;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  done;

  modport master (
    output start, stop, cfg_we, cfg_ch, cfg_addr, cfg_wdata,
    input  cfg_err, tmr_out, busy, done
  );

  modport slave (
    input  start, stop, cfg_we, cfg_ch, cfg_addr, cfg_wdata,
    output cfg_err, tmr_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/vslc_timer_channel.sv
`default_nettype none
// ============================================================================
// vslc_timer_channel : one two-phase timer (prescaler, counter, phase FSM)
// Rev 1.0
// ============================================================================
module vslc_timer_channel
  import vslc_timer_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [CNT_W-1:0] cfg_wdata_i,
  output logic             tmr_out_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int PRE_W = 1 << DIV_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_A    = 2'd1;
  localparam logic [1:0] ST_B    = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [CNT_W-1:0] pa_q, pa_d, pb_q, pb_d, cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  tmr_mode_e        mode_q, mode_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       st_q, st_d;
  logic             out_q, out_d, done_q, done_d;

  logic [CNT_W-1:0] w_pa, w_pb, w_per;
  logic [DIV_W-1:0] w_div;
  tmr_mode_e        w_mode;
  logic [PRE_W-1:0] w_pre_lim;
  logic             w_ctrl_wr, w_running, w_tick, w_end;

  // A write in the same cycle as a start or tick is seen before the register updates.
  assign w_ctrl_wr = cfg_we_i && (cfg_addr_i == CFG_CTRL);
  assign w_pa      = (cfg_we_i && cfg_addr_i == CFG_PA) ? cfg_wdata_i : pa_q;
  assign w_pb      = (cfg_we_i && cfg_addr_i == CFG_PB) ? cfg_wdata_i : pb_q;
  assign w_div     = w_ctrl_wr ? cfg_wdata_i[DIV_W-1:0] : div_q;
  assign w_mode    = w_ctrl_wr ? tmr_mode_e'(cfg_wdata_i[DIV_W +: 2]) : mode_q;
  assign w_pre_lim = ~({PRE_W{1'b1}} << w_div);
  assign w_running = (st_q == ST_A) || (st_q == ST_B);
  assign w_tick    = w_running && (pre_q == w_pre_lim);
  assign w_per     = (st_q == ST_B) ? w_pb : w_pa;
  assign w_end     = w_tick && (cnt_q >= w_per);

  always_comb begin
    pa_d   = w_pa;
    pb_d   = w_pb;
    div_d  = w_div;
    mode_d = w_mode;
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    out_d  = out_q;
    done_d = 1'b0;

    if (stop_i) begin
      st_d  = ST_IDLE;
      out_d = 1'b0;
      cnt_d = '0;
      pre_d = '0;
    end else if (start_i && (st_q == ST_IDLE || w_mode == TMR_RETRIG)) begin
      st_d  = ST_A;
      cnt_d = '0;
      pre_d = '0;
      out_d = (w_mode != TMR_DELAY_ON);
    end else if (w_running) begin
      if (!w_tick) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        if (!w_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (st_q == ST_A) begin
            if (mode_q == TMR_DELAY_ON) begin
              st_d   = ST_HOLD;
              out_d  = 1'b1;
              done_d = 1'b1;
            end else if (mode_q != TMR_CYCLE && w_pb == '0) begin
              st_d   = ST_IDLE;
              out_d  = 1'b0;
              done_d = 1'b1;
            end else begin
              st_d  = ST_B;
              out_d = 1'b0;
            end
          end else begin
            done_d = 1'b1;
            if (mode_q == TMR_CYCLE) begin
              st_d  = ST_A;
              out_d = 1'b1;
            end else begin
              st_d  = ST_IDLE;
              out_d = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_q   <= CNT_W'(PA_RST);
      pb_q   <= CNT_W'(PB_RST);
      div_q  <= '0;
      mode_q <= TMR_CYCLE;
      pre_q  <= '0;
      cnt_q  <= '0;
      st_q   <= ST_IDLE;
      out_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign tmr_out_o = out_q;
  assign busy_o    = (st_q != ST_IDLE);
  assign done_o    = done_q;

endmodule
`default_nettype wire

// File: rtl/vslc_timer_bank.sv
`default_nettype none
// ============================================================================
// vslc_timer_bank : N independent two-phase timers with shared config port
// Rev 1.0
// ============================================================================
module vslc_timer_bank
  import vslc_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 10,
  parameter int DIV_W = 4,
  parameter int CH_W  = 2
) (
  input logic              clk,
  input logic              rst_n,
  vslc_timer_bank_if.slave bus
);
  logic [CH_W-1:0] w_ch;
  logic [N_CH-1:0] w_busy, w_out, w_done, w_ch_we;
  logic            w_in_range, w_tgt_busy, w_drop;
  logic            cfg_err_q, cfg_err_d;

  assign w_ch = bus.cfg_ch;

  // Ctrl registers are frozen while a channel runs; such writes are refused.
  always_comb begin
    w_tgt_busy = 1'b0;
    w_ch_we    = '0;
    w_in_range = (32'(w_ch) < 32'(N_CH));
    for (int i = 0; i < N_CH; i++) begin
      if (32'(w_ch) == 32'(i)) w_tgt_busy = w_busy[i];
    end
    w_drop = bus.cfg_we && (!w_in_range || (bus.cfg_addr == CFG_RSVD) ||
                            ((bus.cfg_addr == CFG_CTRL) && w_tgt_busy));
    for (int i = 0; i < N_CH; i++) begin
      w_ch_we[i] = bus.cfg_we && !w_drop && (32'(w_ch) == 32'(i));
    end
    cfg_err_d = w_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    vslc_timer_channel #(
      .CNT_W (CNT_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (bus.start[g]),
      .stop_i      (bus.stop[g]),
      .cfg_we_i    (w_ch_we[g]),
      .cfg_addr_i  (bus.cfg_addr),
      .cfg_wdata_i (bus.cfg_wdata),
      .tmr_out_o   (w_out[g]),
      .busy_o      (w_busy[g]),
      .done_o      (w_done[g])
    );
  end

  assign bus.tmr_out = w_out;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vslc_timer_bank.sv
`default_nettype none
// ============================================================================
// tb_vslc_timer_bank : directed stimulus, per-cycle model compare, literal traces
// Rev 1.0
// ============================================================================
module tb_vslc_timer_bank;
  localparam int NCH = 4;
  localparam int CW  = 10;
  localparam int DW  = 4;
  localparam int CHW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vslc_timer_bank_if #(.N_CH(NCH), .CNT_W(CW), .CH_W(CHW)) tif();

  vslc_timer_bank #(.N_CH(NCH), .CNT_W(CW), .DIV_W(DW), .CH_W(CHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: per channel, ticks completed in the phase and clocks since last tick.
  int pa[NCH], pb[NCH], dv[NCH], md[NCH], tk[NCH], pc[NCH];
  bit run[NCH], inb[NCH], hold[NCH];
  logic [NCH-1:0] m_out, m_done;
  logic m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      pa[i] = 1; pb[i] = 2; dv[i] = 0; md[i] = 0; tk[i] = 0; pc[i] = 0;
      run[i] = 0; inb[i] = 0; hold[i] = 0;
    end
    m_out = '0; m_done = '0; m_err = 1'b0;
  endfunction

  function automatic void m_step();
    logic [NCH-1:0] st = tif.start;
    logic [NCH-1:0] sp = tif.stop;
    int ch = int'(tif.cfg_ch);
    int a  = int'(tif.cfg_addr);
    int wd = int'(tif.cfg_wdata);
    m_err = 1'b0;
    m_done = '0;
    if (tif.cfg_we) begin
      if (ch >= NCH || a == 3 || (a == 2 && (run[ch] || hold[ch]))) m_err = 1'b1;
      else if (a == 0) pa[ch] = wd;
      else if (a == 1) pb[ch] = wd;
      else begin dv[ch] = wd % 16; md[ch] = (wd / 16) % 4; end
    end
    for (int i = 0; i < NCH; i++) begin
      if (sp[i]) begin
        run[i] = 0; inb[i] = 0; hold[i] = 0; m_out[i] = 1'b0;
      end else if (st[i] && (!(run[i] || hold[i]) || md[i] == 2)) begin
        run[i] = 1; inb[i] = 0; hold[i] = 0; tk[i] = 0; pc[i] = 0;
        m_out[i] = (md[i] != 3);
      end else if (run[i]) begin
        pc[i]++;
        if (pc[i] == (1 << dv[i])) begin
          pc[i] = 0;
          if (tk[i] < (inb[i] ? pb[i] : pa[i])) tk[i]++;
          else begin
            tk[i] = 0;
            if (!inb[i]) begin
              if (md[i] == 3) begin
                run[i] = 0; hold[i] = 1; m_out[i] = 1'b1; m_done[i] = 1'b1;
              end else if (md[i] != 0 && pb[i] == 0) begin
                run[i] = 0; m_out[i] = 1'b0; m_done[i] = 1'b1;
              end else begin
                inb[i] = 1; m_out[i] = 1'b0;
              end
            end else begin
              m_done[i] = 1'b1;
              inb[i] = 0;
              if (md[i] == 0) m_out[i] = 1'b1;
              else begin run[i] = 0; m_out[i] = 1'b0; end
            end
          end
        end
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_reset();
    else        m_step();
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_tmr_out", 32'(tif.tmr_out), 32'(m_out));
    chk("cyc_busy", 32'(tif.busy), 32'({hold[3] | run[3], hold[2] | run[2], hold[1] | run[1], hold[0] | run[0]}));
    chk("cyc_done", 32'(tif.done), 32'(m_done));
    chk("cyc_cfg_err", 32'(tif.cfg_err), 32'(m_err));
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its end, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic cfg_wr(input int ch, input int a, input int d);
    tif.cfg_we = 1'b1; tif.cfg_ch = CHW'(ch); tif.cfg_addr = 2'(a); tif.cfg_wdata = CW'(d);
    @(negedge clk);
    tif.cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [NCH-1:0] s, input logic [NCH-1:0] p);
    tif.start = s; tif.stop = p;
    @(negedge clk);
    tif.start = '0; tif.stop = '0;
  endtask

  task automatic trace(input int ch, input int n, output logic [31:0] ob, output logic [31:0] db);
    ob = '0; db = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      ob = {ob[30:0], tif.tmr_out[ch]};
      db = {db[30:0], tif.done[ch]};
      @(negedge clk);
    end
  endtask

  logic [31:0] ob, db;
  int k;

  initial begin
    tif.start = '0; tif.stop = '0; tif.cfg_we = 1'b0;
    tif.cfg_ch = '0; tif.cfg_addr = '0; tif.cfg_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tmr_out", 32'(tif.tmr_out), 32'h0);
    chk("rst_busy", 32'(tif.busy), 32'h0);
    chk("rst_done", 32'(tif.done), 32'h0);
    chk("rst_cfg_err", 32'(tif.cfg_err), 32'h0);
    @(negedge clk);

    // ch0 CYCLE d=0 pa=2 pb=1
    cfg_wr(0, 2, 0); cfg_wr(0, 0, 2); cfg_wr(0, 1, 1);
    pulse(4'b0001, 4'b0000);
    trace(0, 12, ob, db);
    chk("ch0_cycle_out", ob, 32'b111001110011);
    chk("ch0_cycle_done", db, 32'b000001000010);

    // dropped writes
    cfg_wr(0, 2, 16);
    #1 chk("err_ctrl_busy", 32'(tif.cfg_err), 32'h1);
    cfg_wr(4, 0, 5);
    #1 chk("err_bad_ch", 32'(tif.cfg_err), 32'h1);
    cfg_wr(1, 3, 0);
    #1 chk("err_rsvd_addr", 32'(tif.cfg_err), 32'h1);
    @(negedge clk);
    #1 chk("err_one_cycle", 32'(tif.cfg_err), 32'h0);
    repeat (6) @(negedge clk);
    #1 chk("ch0_mode_kept", 32'(tif.busy[0]), 32'h1);

    // ch1 ONESHOT d=2 pa=0 pb=0
    cfg_wr(1, 2, 18); cfg_wr(1, 0, 0); cfg_wr(1, 1, 0);
    pulse(4'b0010, 4'b0000);
    trace(1, 8, ob, db);
    chk("ch1_oneshot_out", ob, 32'b11110000);
    chk("ch1_oneshot_done", db, 32'b00001000);
    #1 chk("ch1_idle_after", 32'(tif.busy[1]), 32'h0);

    // ch2 RETRIGGER d=0 pa=5, restart at clk 3
    cfg_wr(2, 2, 32); cfg_wr(2, 0, 5);
    pulse(4'b0100, 4'b0000);
    trace(2, 2, ob, db);
    chk("ch2_pre_retrig", ob, 32'b11);
    pulse(4'b0100, 4'b0000);
    trace(2, 10, ob, db);
    chk("ch2_retrig_out", ob, 32'b1111110000);
    chk("ch2_retrig_done", db, 32'b0000000001);

    // config write and start together: new pa=0 used by this start
    tif.cfg_we = 1'b1; tif.cfg_ch = 3'd2; tif.cfg_addr = 2'd0; tif.cfg_wdata = '0;
    pulse(4'b0100, 4'b0000);
    tif.cfg_we = 1'b0;
    trace(2, 5, ob, db);
    chk("ch2_wr_start_out", ob, 32'b10000);
    chk("ch2_wr_start_done", db, 32'b00001);

    // ch3 DELAY_ON pa=3
    cfg_wr(3, 2, 48); cfg_wr(3, 0, 3);
    pulse(4'b1000, 4'b0000);
    trace(3, 8, ob, db);
    chk("ch3_delay_out", ob, 32'b00001111);
    chk("ch3_delay_done", db, 32'b00001000);
    pulse(4'b0000, 4'b1000);
    #1;
    chk("ch3_stop_out", 32'(tif.tmr_out[3]), 32'h0);
    chk("ch3_stop_busy", 32'(tif.busy[3]), 32'h0);
    chk("ch3_stop_nodone", 32'(tif.done[3]), 32'h0);
    pulse(4'b1000, 4'b1000);
    #1 chk("ch3_start_stop", 32'(tif.busy[3]), 32'h0);

    // ch1 period_a shrunk from 10 to 2 while counter=6
    cfg_wr(1, 2, 16); cfg_wr(1, 0, 10);
    pulse(4'b0010, 4'b0000);
    repeat (6) @(negedge clk);
    #1 chk("ch1_before_shrink", 32'(tif.tmr_out[1]), 32'h1);
    cfg_wr(1, 0, 2);
    #1;
    chk("ch1_shrink_out", 32'(tif.tmr_out[1]), 32'h0);
    chk("ch1_shrink_done", 32'(tif.done[1]), 32'h1);

    // async reset mid-run on ch0
    k = 0;
    while (tif.tmr_out[0] !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    chk("arst_wait_high", 32'(k < 10), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tmr_out", 32'(tif.tmr_out), 32'h0);
    chk("arst_busy", 32'(tif.busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(4'b0001, 4'b0000);
    trace(0, 10, ob, db);
    chk("ch0_default_out", ob, 32'b1100011000);
    chk("ch0_default_done", db, 32'b0000010000);

    pulse(4'b0000, 4'b1111);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vslc_timer_bank.md
Name: vslc_timer_bank

Overview:
- Parametrised bank of N independent two-phase timers for the VSLC controller.
- Replaces the single hard-wired 10-bit timer and adds configurable channel count, counter width, prescaler range, a per-channel config port, and retrigger and delay-on modes.
- Sits beside the instruction executor. The executor issues start/stop strobes and config writes; channel outputs drive uo_out bits.

Parameters:
- N_CH, 4, number of timer channels (1..8).
- CNT_W, 10, period/counter width in bits.
- DIV_W, 4, prescaler divisor field width; divisor d gives one tick every 2^d clocks, d max 2^DIV_W-1.
- CH_W, 2, channel index width, clog2(N_CH) with a minimum of 1.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  N_CH  per-channel start strobe, sampled each clk.
- stop  in  N_CH  per-channel stop strobe.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  target channel.
- cfg_addr  in  2  0=period_a, 1=period_b, 2=ctrl {mode[1:0], divisor[DIV_W-1:0]} LSB-aligned, 3=reserved.
- cfg_wdata  in  CNT_W  write data.
- cfg_err  out  1  one-cycle pulse when a config write is dropped.
- tmr_out  out  N_CH  registered timer outputs.
- busy  out  N_CH  channel running.
- done  out  N_CH  one-cycle completion pulse.

Behaviour:
- All state sits in rising-edge flops with async clear.
- Reset values: tmr_out=0, busy=0, done=0, cfg_err=0, period_a=1, period_b=2, divisor=0, mode=CYCLE, prescaler=0, counter=0, phase=A.
- Prescaler: PRE counter, width 2^DIV_W bits. It increments each clk while busy. A tick occurs when PRE==2^d-1, and PRE then clears. With d=0 every clk is a tick. PRE clears on start and on stop.
- Phase counter: counts ticks. A phase ends on the tick where counter>=period (use >=, so a period shrunk below the current count ends at the next tick). The counter then clears and the phase toggles. Phase A therefore lasts period_a+1 ticks and phase B lasts period_b+1 ticks.
- Start: start[i] at edge k while idle gives busy=1, phase=A and tmr_out per mode from edge k+1 (1 cycle latency).
- Modes:
  - CYCLE (0): out=1 in A, 0 in B. Repeats A/B until stop. done pulses at every end of B.
  - ONESHOT (1): A then B once, with out as in CYCLE. At the end of B: busy=0, out=0, done=1. If period_b==0, B is skipped and the channel finishes at the end of A.
  - RETRIGGER (2): behaves as ONESHOT, but start while busy restarts phase A with the counter and PRE cleared, and out stays 1 without a glitch.
  - DELAY_ON (3): out=0 during A. At the end of A, out=1 and stays 1 with busy=1 until stop. B is not used. done pulses at the end of A.
- start while busy in modes 0, 1 and 3 is ignored.
- stop[i]: the next edge gives busy=0, tmr_out=0 and phase=A; done is not pulsed. Simultaneous start and stop: stop wins. stop while idle is a no-op.
- Config writes:
  - Period writes take effect immediately, including while running.
  - A ctrl write while the channel is busy is dropped.
  - A write with cfg_ch>=N_CH or cfg_addr==3 is dropped.
  - Every dropped write pulses cfg_err for 1 cycle.
- Simultaneous cfg write and start to the same channel: the write lands first and the start uses the new value.
- Counter arithmetic is unsigned CNT_W bits and never wraps: the >= compare guarantees termination.
- Async reset mid-run clears everything immediately; outputs go low without waiting for clk.

Decomposition:
- Package vslc_timer_pkg holds:
  - the mode enum: TMR_CYCLE, TMR_ONESHOT, TMR_RETRIG, TMR_DELAY_ON;
  - cfg_addr constants: CFG_PA, CFG_PB, CFG_CTRL;
  - reset defaults: PA_RST=1, PB_RST=2.
- Sub-module vslc_timer_channel holds one channel's prescaler, counter, phase FSM and registers. It is instantiated N_CH times via generate.
- The top level does cfg decode, error detection and bus concatenation.

Test Plan:
- ch0: CYCLE, d=0, pa=2, pb=1, start -> tmr_out[0] high 3 clks, low 2, period 5. done[0] pulses every 5 clks. busy stays 1.
- ch1: ONESHOT, d=2, pa=0, pb=0, start -> out high 4 clks (A only). done[1] pulses once, then busy[1]=0 and out stays 0.
- ch2: RETRIGGER, d=0, pa=5, second start at clk 3 -> out continuously high 3+6=9 clks, single done pulse.
- ch3: DELAY_ON, pa=3, start -> out low 4 clks, then high until stop. stop gives out=0 next clk with no done. start and stop in the same clk -> busy stays 0.
- Config errors: ctrl write to a busy ch0 -> cfg_err=1 for 1 clk and mode unchanged. cfg_ch=4 with N_CH=4 -> cfg_err. pa rewrite 10->2 while counter=6 -> phase ends at the next tick.
- rst_n low mid-CYCLE, asserted between clk edges -> tmr_out/busy go to 0 immediately. After release, period_a=1 and period_b=2 (defaults), and a new start yields high 2 clks, low 3.
